// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N
// producers. A producer is granted for a burst of up to BURST words, and the
// grant is released early when the producer drops req. Every release costs
// one IDLE cycle before the next grant. fifo_full stalls the grant without
// giving it up.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active high
//   req        [N]    requester i holds a valid word
//   req_data   [N*W]  requester i's word on bits [i*W +: W]
//   fifo_full         FIFO full flag; blocks writes in the same cycle
//   ack        [N]    one-hot; the word of requester i is written this edge
//   fifo_wr           FIFO write enable
//   fifo_data  [W]    FIFO write data (zero while idle)
//   owner             granted requester index, valid while busy
//   busy              a grant is active
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_data,
  input  logic                 fifo_full,
  output logic [N-1:0]         ack,
  output logic                 fifo_wr,
  output logic [W-1:0]         fifo_data,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [N-1:0][W-1:0] data_arr;
  assign data_arr = req_data;

  // Round-robin pick: scan ptr, ptr+1, ... mod N. The loop runs from the far
  // end so the last hit written is the one closest to ptr.
  logic [OW-1:0] pick;
  logic          pick_vld;
  logic [OW-1:0] cand;
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = OW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  logic [OW-1:0] owner_nxt;
  assign owner_nxt = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;

  // Write path is combinational from the registered grant, so fifo_full and
  // a dropped req take effect in the same cycle. It is deliberately not gated
  // by reset: a word acked in the reset cycle is really written.
  assign busy      = (state == GRANT);
  assign fifo_wr   = busy & req[owner] & ~fifo_full;
  assign ack       = fifo_wr ? (N'(1) << owner) : '0;
  assign fifo_data = busy ? data_arr[owner] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (fifo_wr) begin
            if (cnt == CW'(BURST - 1)) begin
              state <= IDLE;
              ptr   <= owner_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (!req[owner]) begin
            // producer ran dry: release without a write
            state <= IDLE;
            ptr   <= owner_nxt;
          end
          // else: req held but FIFO full -> stall, hold owner and cnt
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 8-bit synchronous FIFO among N producers. Each producer presents a word with a valid/ack handshake. The arbiter grants one producer at a time for a burst of up to BURST words. It drives the FIFO `wr`/`data` inputs and respects the FIFO `full` flag. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `N`, 4: number of requesters (2..8).
- `W`, 8: data width; matches the FIFO data width.
- `BURST`, 4: maximum words per grant (1..16).
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high. Dominates every other input.
- `req`, in, N: `req[i]` high means requester i holds a valid word on its data slice.
- `req_data`, in, N*W: requester i's word on bits `[i*W +: W]`.
- `fifo_full`, in, 1: FIFO full flag.
- `ack`, out, N: one-hot. `ack[i]` high means requester i's word is written on this edge.
- `fifo_wr`, out, 1: FIFO write enable.
- `fifo_data`, out, W: FIFO write data.
- `owner`, out, clog2(N): index of the granted requester; valid while `busy`.
- `busy`, out, 1: a grant is active (state GRANT).

## Operation
- Registered state:
  - `state` ∈ {IDLE, GRANT}
  - `owner`
  - `ptr`: round-robin priority start
  - `cnt`: words written in the current grant, width clog2(BURST)+1
- IDLE:
  - If any `req` bit is high, pick the first set bit scanning `ptr`, `ptr+1`, … mod N.
  - Load `owner` with that index, clear `cnt`, go to GRANT.
  - No write occurs in IDLE.
- GRANT, combinational outputs:
  - `fifo_wr = req[owner] & ~fifo_full`
  - `ack = fifo_wr ? (1 << owner) : 0`
  - `fifo_data = busy ? req_data[owner] : 0`
- GRANT transitions, evaluated at each edge:
  - `fifo_wr` high and `cnt == BURST-1`: go to IDLE, `ptr <= owner+1` mod N.
  - `fifo_wr` high, otherwise: `cnt <= cnt+1`, stay in GRANT.
  - `req[owner]` low: go to IDLE with no write, `ptr <= owner+1` mod N. The producer has no more data.
  - `req[owner]` high and `fifo_full` high: stall. Hold `owner` and `cnt`; no ack.
- Requester contract:
  - Hold `req` and data stable until `ack` is seen.
  - A word is consumed on the edge where its `ack` is high.
  - The requester may present the next word or drop `req` in the following cycle.
- Non-owners never receive `ack`. Their `req` is ignored until re-arbitration.
- Each release costs one IDLE bubble cycle before the next grant.
- Reset, whether in IDLE or mid-burst:
  - `state`=IDLE, `owner`=0, `ptr`=0, `cnt`=0 at the next edge.
  - A word whose `ack` was high in the reset cycle counts as written. The FIFO sees `fifo_wr` that cycle.

## Timing
- Reset values: `busy`=0, `owner`=0, `fifo_wr`=0, `ack`=0, `fifo_data`=0.
- Request to first write latency:
  - req sampled high at edge k (IDLE): `busy`=1 after edge k.
  - First `ack`/`fifo_wr` is asserted combinationally in cycle k+1.
  - The word is written at edge k+1.
- Full burst of BURST words plus release: BURST+1 cycles including the arbitration bubble.
- Throughput: one word per cycle within a grant while not full.
- Sustained with all N requesting: BURST/(BURST+1) of cycles carry writes.
- `fifo_full` takes effect combinationally in the same cycle. `fifo_wr` is never high while `fifo_full` is high.
- Simultaneous release and new requests: the bubble cycle re-arbitrates with the already-updated `ptr`.

## Test plan
- Reset held 2 cycles with random `req` → `busy`=0, `fifo_wr`=0, `ack`=0, `fifo_data`=0, `owner`=0 throughout.
- Only `req[2]` high continuously, data 8'hA5, BURST=4:
  - `busy` rises one cycle after `req`.
  - Four consecutive `ack`=4'b0100 with `fifo_data`=8'hA5.
  - One IDLE cycle, then requester 2 is re-granted.
- All four `req` high, requester i sends 8'h10+i:
  - Grant order is 0,1,2,3,0.
  - Each grant writes exactly 4 words, separated by one bubble.
- `fifo_full` raised for 3 cycles after the 2nd word of a grant to requester 1:
  - `fifo_wr`=0 and `ack`=0 for 3 cycles; `owner`=1 held.
  - Then words 3–4 are written and the grant releases.
- Owner 3 drops `req` after 1 word while `req[0]` is high:
  - Next edge goes IDLE; `ptr` wraps to 0.
  - Requester 0 is granted one cycle later.
- `reset` asserted mid-burst, after 2 of 4 words to requester 2, with all `req` high:
  - `busy`=0 the next cycle.
  - After release of reset, the first grant goes to requester 0.
